// File: rtl/multadd_pkg.sv
// Shared definitions for the multiply-add stage and its downstream accumulator.
package multadd_pkg;

    localparam int unsigned MULTADD_RES_W = 17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } accState_e;

endpackage

// File: rtl/sat_add.sv
// Unsigned saturating add of a zero-extended IN_W addend onto an ACC_W base.
module sat_add #(
    parameter int unsigned IN_W  = 17,
    parameter int unsigned ACC_W = 20
) (
    input  logic [ACC_W-1:0] base,
    input  logic [IN_W-1:0]  addend,
    output logic [ACC_W-1:0] sum,
    output logic             sat
);

    localparam int unsigned WIDE_W = ACC_W + 1;

    logic [ACC_W:0] wide;

    always_comb begin
        wide = {1'b0, base} + WIDE_W'(addend);
        sat  = wide[ACC_W];
        sum  = sat ? '1 : wide[ACC_W-1:0];
    end

endmodule

// File: rtl/multadd_accum.sv
// Sums windows of N_TERMS multiply-add results and hands each sum downstream via valid/ready.
module multadd_accum
    import multadd_pkg::*;
#(
    parameter int unsigned IN_W    = MULTADD_RES_W,
    parameter int unsigned ACC_W   = 20,
    parameter int unsigned N_TERMS = 8,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iCLR,
    input  logic             iVALID,
    input  logic [IN_W-1:0]  iRESULT,
    output logic             oREADY,
    output logic [ACC_W-1:0] oSUM,
    output logic             oVALID,
    input  logic             iREADY,
    output logic             oOVF,
    output logic             oDROP
);

    accState_e        state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic [ACC_W-1:0] addBase;
    logic [ACC_W-1:0] addSum;
    logic             addSat;
    logic [CNT_W-1:0] cntNext;
    logic             windowDone;
    logic             accept;

    // Only ACC continues a window; IDLE and HOLD start a fresh one from zero.
    always_comb begin
        addBase    = (state == ACC) ? acc : '0;
        cntNext    = (state == ACC) ? cnt + CNT_W'(1) : CNT_W'(1);
        windowDone = (cntNext == CNT_W'(N_TERMS));
        oREADY     = (state != HOLD) | iREADY;
        accept     = iVALID & oREADY;
    end

    sat_add #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) uSatAdd (
        .base   (addBase),
        .addend (iRESULT),
        .sum    (addSum),
        .sat    (addSat)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            oSUM   <= '0;
            oVALID <= 1'b0;
            oOVF   <= 1'b0;
            oDROP  <= 1'b0;
        end else if (iCLR) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            oVALID <= 1'b0;
            oOVF   <= 1'b0;
            oDROP  <= 1'b0;
        end else begin
            oDROP <= 1'b0;
            if (state == HOLD) begin
                if (iREADY) begin
                    oVALID <= 1'b0;
                    state  <= IDLE;
                end else if (iVALID) begin
                    oDROP <= 1'b1;
                end
            end
            // An accepted sample in HOLD overrides the IDLE return and opens the next window.
            if (accept) begin
                acc  <= addSum;
                oOVF <= oOVF | addSat;
                if (windowDone) begin
                    oSUM   <= addSum;
                    oVALID <= 1'b1;
                    cnt    <= '0;
                    state  <= HOLD;
                end else begin
                    cnt   <= cntNext;
                    state <= ACC;
                end
            end
        end
    end

endmodule

// File: tb/tb_multadd_accum.sv
// Directed bench for multadd_accum: default instance plus a narrow 4-term instance for saturation.
module tb_multadd_accum;

    logic        clk;
    logic        rst;

    logic        clr0, valid0, ready0;
    logic [16:0] result0;
    logic        oReady0, oValid0, oOvf0, oDrop0;
    logic [19:0] oSum0;

    logic        clr1, valid1, ready1;
    logic [16:0] result1;
    logic        oReady1, oValid1, oOvf1, oDrop1;
    logic [17:0] oSum1;

    int checks = 0;
    int errors = 0;
    int drops;

    multadd_accum dut0 (
        .iCLK    (clk),
        .iRST    (rst),
        .iCLR    (clr0),
        .iVALID  (valid0),
        .iRESULT (result0),
        .oREADY  (oReady0),
        .oSUM    (oSum0),
        .oVALID  (oValid0),
        .iREADY  (ready0),
        .oOVF    (oOvf0),
        .oDROP   (oDrop0)
    );

    multadd_accum #(
        .IN_W    (17),
        .ACC_W   (18),
        .N_TERMS (4),
        .CNT_W   (8)
    ) dut1 (
        .iCLK    (clk),
        .iRST    (rst),
        .iCLR    (clr1),
        .iVALID  (valid1),
        .iRESULT (result1),
        .oREADY  (oReady1),
        .oSUM    (oSum1),
        .oVALID  (oValid1),
        .iREADY  (ready1),
        .oOVF    (oOvf1),
        .oDROP   (oDrop1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, want);
        end
    endtask

    // Drive one cycle on dut0 and sample just after the rising edge.
    task automatic step0(input logic v, input logic [16:0] r, input logic rdy, input logic c);
        @(negedge clk);
        valid0  = v;
        result0 = r;
        ready0  = rdy;
        clr0    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic step1(input logic v, input logic [16:0] r, input logic rdy, input logic c);
        @(negedge clk);
        valid1  = v;
        result1 = r;
        ready1  = rdy;
        clr1    = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        {clr0, valid0, ready0} = '0;
        {clr1, valid1, ready1} = '0;
        result0 = '0;
        result1 = '0;
        #3;
        checkVal("rst_sum", 32'(oSum0), 0);
        checkVal("rst_valid", 32'(oValid0), 0);
        checkVal("rst_ovf", 32'(oOvf0), 0);
        checkVal("rst_drop", 32'(oDrop0), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkVal("rst_ready", 32'(oReady0), 1);

        // 1: eight samples of 8
        for (int i = 0; i < 7; i++) step0(1'b1, 17'd8, 1'b1, 1'b0);
        checkVal("t1_early_valid", 32'(oValid0), 0);
        step0(1'b1, 17'd8, 1'b1, 1'b0);
        checkVal("t1_valid", 32'(oValid0), 1);
        checkVal("t1_sum", 32'(oSum0), 64);
        checkVal("t1_ovf", 32'(oOvf0), 0);
        step0(1'b0, 17'd0, 1'b1, 1'b0);
        checkVal("t1_valid_fall", 32'(oValid0), 0);

        // 2: max-valued samples with random gaps
        for (int i = 0; i < 8; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) step0(1'b0, 17'd0, 1'b1, 1'b0);
            step0(1'b1, 17'd130050, 1'b1, 1'b0);
        end
        checkVal("t2_valid", 32'(oValid0), 1);
        checkVal("t2_sum", 32'(oSum0), 1040400);
        checkVal("t2_ovf", 32'(oOvf0), 0);
        step0(1'b0, 17'd0, 1'b1, 1'b0);

        // 3: saturation on the narrow instance, sticky until clear
        for (int i = 0; i < 4; i++) step1(1'b1, 17'd130050, 1'b1, 1'b0);
        checkVal("t3_valid", 32'(oValid1), 1);
        checkVal("t3_sum", 32'(oSum1), 262143);
        checkVal("t3_ovf", 32'(oOvf1), 1);
        for (int i = 0; i < 4; i++) step1(1'b1, 17'd10, 1'b1, 1'b0);
        checkVal("t3_clean_sum", 32'(oSum1), 40);
        checkVal("t3_ovf_sticky", 32'(oOvf1), 1);
        step1(1'b0, 17'd0, 1'b1, 1'b1);
        checkVal("t3_ovf_clr", 32'(oOvf1), 0);
        step1(1'b0, 17'd0, 1'b0, 1'b0);

        // 4: stall in HOLD with drops, then restart on the releasing cycle
        for (int i = 0; i < 8; i++) step0(1'b1, 17'd3, 1'b0, 1'b0);
        checkVal("t4_valid", 32'(oValid0), 1);
        checkVal("t4_sum", 32'(oSum0), 24);
        checkVal("t4_ready_low", 32'(oReady0), 0);
        drops = 0;
        for (int i = 0; i < 5; i++) begin
            step0((i == 0) || (i == 2), 17'd100, 1'b0, 1'b0);
            if (oDrop0 === 1'b1) drops++;
        end
        checkVal("t4_drops", 32'(drops), 2);
        checkVal("t4_sum_held", 32'(oSum0), 24);
        checkVal("t4_valid_held", 32'(oValid0), 1);
        step0(1'b1, 17'd5, 1'b1, 1'b0);
        checkVal("t4_valid_fall", 32'(oValid0), 0);
        for (int i = 0; i < 7; i++) step0(1'b1, 17'd1, 1'b1, 1'b0);
        checkVal("t4_next_valid", 32'(oValid0), 1);
        checkVal("t4_next_sum", 32'(oSum0), 12);
        step0(1'b0, 17'd0, 1'b1, 1'b0);

        // 5: async reset mid-window and mid-HOLD
        for (int i = 0; i < 3; i++) step0(1'b1, 17'd7, 1'b0, 1'b0);
        step0(1'b0, 17'd0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkVal("t5_win_sum", 32'(oSum0), 0);
        checkVal("t5_win_valid", 32'(oValid0), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkVal("t5_win_ready", 32'(oReady0), 1);
        for (int i = 0; i < 8; i++) step0(1'b1, 17'd1, 1'b0, 1'b0);
        checkVal("t5_sum", 32'(oSum0), 8);
        checkVal("t5_hold_valid", 32'(oValid0), 1);
        #2;
        rst = 1'b1;
        #1;
        checkVal("t5_hold_sum", 32'(oSum0), 0);
        checkVal("t5_hold_valid_rst", 32'(oValid0), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkVal("t5_hold_ready", 32'(oReady0), 1);
        for (int i = 0; i < 8; i++) step0(1'b1, 17'd1, 1'b1, 1'b0);
        checkVal("t5_after_sum", 32'(oSum0), 8);
        step0(1'b0, 17'd0, 1'b1, 1'b0);

        // 6: clear with a concurrent sample at cnt=5
        for (int i = 0; i < 5; i++) step0(1'b1, 17'd9, 1'b1, 1'b0);
        step0(1'b1, 17'd50, 1'b1, 1'b1);
        checkVal("t6_clr_drop", 32'(oDrop0), 0);
        checkVal("t6_clr_valid", 32'(oValid0), 0);
        for (int i = 0; i < 7; i++) step0(1'b1, 17'd2, 1'b1, 1'b0);
        checkVal("t6_early_valid", 32'(oValid0), 0);
        step0(1'b1, 17'd2, 1'b1, 1'b0);
        checkVal("t6_valid", 32'(oValid0), 1);
        checkVal("t6_sum", 32'(oSum0), 16);
        step0(1'b0, 17'd0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
